// File: rtl/ascii_cell_renderer_pkg.sv
// Shared VGA ASCII constants: raster geometry, cell/glyph widths, pipeline latency
// and the multiplier-free row-major cell index helper.
package ascii_cell_renderer_pkg;

  localparam int unsigned H_ACTIVE_DEF     = 640;
  localparam int unsigned V_ACTIVE_DEF     = 480;
  localparam int unsigned COLS_DEF         = 80;
  localparam int unsigned BLINK_FRAMES_DEF = 30;
  localparam int unsigned CELL_SIZE        = 8;
  localparam int unsigned CELL_SHIFT       = 3;
  localparam int unsigned COORD_W          = 12;
  localparam int unsigned CELL_AW          = 13;
  localparam int unsigned CODE_W           = 4;
  localparam int unsigned GLYPH_AW         = 10;
  localparam int unsigned PIPE_LATENCY     = 4;

  typedef logic [CELL_AW-1:0] cell_addr_t;
  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [COORD_W-CELL_SHIFT-1:0] cell_coord_t;

  // row*cols + col built from one shifted copy of row per set bit of cols
  // (80 -> row<<6 + row<<4); cols is a constant so this folds to adders only.
  function automatic cell_addr_t cell_index(input cell_coord_t row_cell,
                                            input cell_coord_t col_cell,
                                            input int unsigned cols);
    cell_addr_t acc;
    acc = cell_addr_t'(col_cell);
    for (int unsigned b = 0; b < CELL_AW; b++) begin
      if (cols[b]) acc = acc + (cell_addr_t'(row_cell) << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/ascii_cell_renderer_if.sv
// Cell buffer and glyph ROM read ports; both memories return data one cycle
// after the address is presented.
interface ascii_cell_renderer_if;
  import ascii_cell_renderer_pkg::*;

  logic [CELL_AW-1:0]  cell_addr;
  logic                cell_rd_en;
  logic [CODE_W-1:0]   cell_data;
  logic [GLYPH_AW-1:0] glyph_addr;
  logic                glyph_data;

  modport master (output cell_addr, cell_rd_en, glyph_addr,
                  input  cell_data, glyph_data);
  modport slave  (input  cell_addr, cell_rd_en, glyph_addr,
                  output cell_data, glyph_data);
endinterface

// File: rtl/ascii_blink_timer.sv
// Cursor blink timer: counts frame-start ticks and toggles the phase every
// BLINK_FRAMES ticks.
module ascii_blink_timer #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  output logic blink_o
);
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (tick_i) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_o = phase_q;
endmodule

// File: rtl/ascii_cell_renderer.sv
// Character-cell renderer: coordinates -> cell fetch -> glyph lookup -> pixel,
// fixed 4-cycle latency from the sampled coordinates to ascii_pix/pix_valid.
module ascii_cell_renderer
  import ascii_cell_renderer_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned COLS         = COLS_DEF,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic                     vga_clk,
  input  logic                     reset,
  input  logic                     video_on,
  input  logic [COORD_W-1:0]       pixel_row,
  input  logic [COORD_W-1:0]       pixel_column,
  input  logic                     cursor_en,
  input  logic [CELL_AW-1:0]       cursor_addr,
  ascii_cell_renderer_if.master    mem,
  output logic                     ascii_pix,
  output logic                     pix_valid
);

  logic       in_range, valid_d, fetch_d, hit_d, frame_tick, blink_phase;
  cell_addr_t cell_addr_d;

  logic       valid1_q, fetch1_q, hit1_q;
  cell_addr_t cell_addr_q;
  logic [2:0] sub_row1_q, sub_col1_q;
  logic       valid2_q, fetch2_q, hit2_q;
  logic [2:0] sub_row2_q, sub_col2_q;
  logic       valid3_q, hit3_q, valid4_q, hit4_q;
  code_t      code_q, code_d;
  logic [GLYPH_AW-1:0] glyph_addr_q, glyph_addr_d;
  logic       pix_q, pix_d, pvalid_q;

  always_comb begin
    in_range    = (32'(pixel_column) < H_ACTIVE) && (32'(pixel_row) < V_ACTIVE);
    valid_d     = video_on && in_range;
    fetch_d     = valid_d && (pixel_column[2:0] == 3'd0);
    cell_addr_d = cell_index(pixel_row[COORD_W-1:CELL_SHIFT],
                             pixel_column[COORD_W-1:CELL_SHIFT], COLS);
    hit_d       = cursor_en && (cell_addr_d == cursor_addr) && blink_phase;
    frame_tick  = video_on && (pixel_row == '0) && (pixel_column == '0);
  end

  ascii_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk_i   (vga_clk),
    .rst_i   (reset),
    .tick_i  (frame_tick),
    .blink_o (blink_phase)
  );

  // The fetch pixel's code is still on cell_data; later pixels of the cell
  // use the captured copy.
  always_comb begin
    code_d       = fetch2_q ? mem.cell_data : code_q;
    glyph_addr_d = {code_d, sub_row2_q, sub_col2_q};
    pix_d        = valid4_q && (mem.glyph_data ^ hit4_q);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      cell_addr_q  <= '0;
      sub_row1_q   <= '0;
      sub_col1_q   <= '0;
      valid1_q     <= 1'b0;
      fetch1_q     <= 1'b0;
      hit1_q       <= 1'b0;
      sub_row2_q   <= '0;
      sub_col2_q   <= '0;
      valid2_q     <= 1'b0;
      fetch2_q     <= 1'b0;
      hit2_q       <= 1'b0;
      code_q       <= '0;
      glyph_addr_q <= '0;
      valid3_q     <= 1'b0;
      hit3_q       <= 1'b0;
      valid4_q     <= 1'b0;
      hit4_q       <= 1'b0;
      pix_q        <= 1'b0;
      pvalid_q     <= 1'b0;
    end else begin
      cell_addr_q  <= cell_addr_d;
      sub_row1_q   <= pixel_row[2:0];
      sub_col1_q   <= pixel_column[2:0];
      valid1_q     <= valid_d;
      fetch1_q     <= fetch_d;
      hit1_q       <= hit_d;
      sub_row2_q   <= sub_row1_q;
      sub_col2_q   <= sub_col1_q;
      valid2_q     <= valid1_q;
      fetch2_q     <= fetch1_q;
      hit2_q       <= hit1_q;
      code_q       <= code_d;
      glyph_addr_q <= glyph_addr_d;
      valid3_q     <= valid2_q;
      hit3_q       <= hit2_q;
      valid4_q     <= valid3_q;
      hit4_q       <= hit3_q;
      pix_q        <= pix_d;
      pvalid_q     <= valid4_q;
    end
  end

  assign mem.cell_addr  = cell_addr_q;
  assign mem.cell_rd_en = fetch1_q;
  assign mem.glyph_addr = glyph_addr_q;
  assign ascii_pix      = pix_q;
  assign pix_valid      = pvalid_q;

endmodule

// File: tb/tb_ascii_cell_renderer.sv
// Directed bench for ascii_cell_renderer with behavioural cell buffer and glyph ROM.
module tb_ascii_cell_renderer;

  logic        vga_clk = 1'b0;
  logic        reset, video_on, cursor_en;
  logic [11:0] pixel_row, pixel_column;
  logic [12:0] cursor_addr;
  logic        ascii_pix, pix_valid;

  always #5 vga_clk = ~vga_clk;

  ascii_cell_renderer_if mem ();

  ascii_cell_renderer #(
    .H_ACTIVE     (640),
    .V_ACTIVE     (480),
    .COLS         (80),
    .BLINK_FRAMES (2)
  ) dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .video_on     (video_on),
    .pixel_row    (pixel_row),
    .pixel_column (pixel_column),
    .cursor_en    (cursor_en),
    .cursor_addr  (cursor_addr),
    .mem          (mem),
    .ascii_pix    (ascii_pix),
    .pix_valid    (pix_valid)
  );

  // glyph_mode: 0 = addr[0], 1 = all zero, 2 = all one, 3 = one only for code 15
  logic [3:0] cell_mem [8192];
  int         glyph_mode;

  function automatic logic glyph_bit(input logic [9:0] a);
    case (glyph_mode)
      0:       return a[0];
      1:       return 1'b0;
      2:       return 1'b1;
      default: return a[9:6] == 4'hF;
    endcase
  endfunction

  always @(posedge vga_clk) begin
    if (mem.cell_rd_en) mem.cell_data <= cell_mem[mem.cell_addr];
    mem.glyph_data <= glyph_bit(mem.glyph_addr);
  end

  int checks = 0;
  int errors = 0;

  localparam int MAXS = 24;
  localparam int MAXO = MAXS + 5;
  logic        seq_vo [MAXS];
  logic        seq_rst[MAXS];
  logic        seq_cen[MAXS];
  logic [11:0] seq_row[MAXS];
  logic [11:0] seq_col[MAXS];
  logic        cen_dflt;

  logic        obs_rd   [MAXO];
  logic [12:0] obs_addr [MAXO];
  logic [9:0]  obs_gaddr[MAXO];
  logic        obs_pix  [MAXO];
  logic        obs_valid[MAXO];

  task automatic set_px(input int j, input logic vo, input int row, input int col);
    seq_vo[j]  = vo;
    seq_row[j] = 12'(row);
    seq_col[j] = 12'(col);
    seq_rst[j] = 1'b0;
    seq_cen[j] = cen_dflt;
  endtask

  // obs index j is sampled just after edge j; pixel j drives rd/addr at j,
  // glyph_addr at j+2 and ascii_pix/pix_valid at j+4.
  task automatic drive_seq(input int n);
    for (int j = 0; j < n + 5; j++) begin
      if (j < n) begin
        video_on     = seq_vo[j];
        pixel_row    = seq_row[j];
        pixel_column = seq_col[j];
        reset        = seq_rst[j];
        cursor_en    = seq_cen[j];
      end else begin
        video_on = 1'b0;
        reset    = 1'b0;
      end
      @(posedge vga_clk); #1;
      obs_rd[j]    = mem.cell_rd_en;
      obs_addr[j]  = mem.cell_addr;
      obs_gaddr[j] = mem.glyph_addr;
      obs_pix[j]   = ascii_pix;
      obs_valid[j] = pix_valid;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; video_on = 1'b1; pixel_row = '0; pixel_column = '0;
    repeat (3) @(posedge vga_clk);
    #1;
    checks++; if (mem.cell_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b exp 0", mem.cell_rd_en); end
    checks++; if (mem.cell_addr !== 13'd0) begin errors++; $display("FAIL reset_cell_addr got %0d exp 0", mem.cell_addr); end
    checks++; if (mem.glyph_addr !== 10'd0) begin errors++; $display("FAIL reset_glyph_addr got %0d exp 0", mem.glyph_addr); end
    checks++; if (ascii_pix !== 1'b0) begin errors++; $display("FAIL reset_ascii_pix got %0b exp 0", ascii_pix); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %0b exp 0", pix_valid); end
    reset = 1'b0; video_on = 1'b0;
  endtask

  task automatic test_glyph_cell;
    logic exp_pix, exp_val;
    glyph_mode = 0;
    cell_mem[0] = 4'd5;
    for (int c = 0; c < 8; c++) set_px(c, 1'b1, 0, c);
    drive_seq(8);
    for (int j = 0; j < 13; j++) begin
      checks++;
      if (obs_rd[j] !== (j == 0)) begin errors++; $display("FAIL cell0_rd_en[%0d] got %0b exp %0b", j, obs_rd[j], (j == 0)); end
      if (j >= 2 && j <= 9) begin
        checks++;
        if (obs_gaddr[j] !== 10'(320 + j - 2)) begin errors++; $display("FAIL cell0_glyph_addr[%0d] got %0d exp %0d", j, obs_gaddr[j], 320 + j - 2); end
      end
      exp_val = (j >= 4 && j <= 11);
      exp_pix = exp_val && (((j - 4) % 2) == 1);
      checks++;
      if (obs_valid[j] !== exp_val) begin errors++; $display("FAIL cell0_pix_valid[%0d] got %0b exp %0b", j, obs_valid[j], exp_val); end
      checks++;
      if (obs_pix[j] !== exp_pix) begin errors++; $display("FAIL cell0_ascii_pix[%0d] got %0b exp %0b", j, obs_pix[j], exp_pix); end
    end
    checks++;
    if (obs_addr[0] !== 13'd0) begin errors++; $display("FAIL cell0_addr got %0d exp 0", obs_addr[0]); end
  endtask

  task automatic test_addr;
    glyph_mode = 1;
    set_px(0, 1'b1, 8, 16);
    set_px(1, 1'b1, 479, 639);
    set_px(2, 1'b1, 479, 632);
    drive_seq(3);
    checks++; if (obs_addr[0] !== 13'd82) begin errors++; $display("FAIL addr_r8c16 got %0d exp 82", obs_addr[0]); end
    checks++; if (obs_rd[0] !== 1'b1) begin errors++; $display("FAIL rd_r8c16 got %0b exp 1", obs_rd[0]); end
    checks++; if (obs_addr[1] !== 13'd4799) begin errors++; $display("FAIL addr_r479c639 got %0d exp 4799", obs_addr[1]); end
    checks++; if (obs_rd[1] !== 1'b0) begin errors++; $display("FAIL rd_r479c639 got %0b exp 0", obs_rd[1]); end
    checks++; if (obs_addr[2] !== 13'd4799) begin errors++; $display("FAIL addr_r479c632 got %0d exp 4799", obs_addr[2]); end
    checks++; if (obs_rd[2] !== 1'b1) begin errors++; $display("FAIL rd_r479c632 got %0b exp 1", obs_rd[2]); end
  endtask

  task automatic test_out_of_range;
    glyph_mode = 2;
    set_px(0, 1'b1, 0, 640);
    set_px(1, 1'b1, 480, 0);
    set_px(2, 1'b1, 479, 632);
    drive_seq(3);
    checks++; if (obs_rd[0] !== 1'b0) begin errors++; $display("FAIL oor_col_rd got %0b exp 0", obs_rd[0]); end
    checks++; if (obs_rd[1] !== 1'b0) begin errors++; $display("FAIL oor_row_rd got %0b exp 0", obs_rd[1]); end
    checks++; if (obs_valid[4] !== 1'b0) begin errors++; $display("FAIL oor_col_valid got %0b exp 0", obs_valid[4]); end
    checks++; if (obs_pix[4] !== 1'b0) begin errors++; $display("FAIL oor_col_pix got %0b exp 0", obs_pix[4]); end
    checks++; if (obs_valid[5] !== 1'b0) begin errors++; $display("FAIL oor_row_valid got %0b exp 0", obs_valid[5]); end
    checks++; if (obs_pix[5] !== 1'b0) begin errors++; $display("FAIL oor_row_pix got %0b exp 0", obs_pix[5]); end
    checks++; if (obs_valid[6] !== 1'b1) begin errors++; $display("FAIL inrange_valid got %0b exp 1", obs_valid[6]); end
    checks++; if (obs_pix[6] !== 1'b1) begin errors++; $display("FAIL inrange_pix got %0b exp 1", obs_pix[6]); end
  endtask

  // Frame 0 is the partial frame in progress when reset releases (no (0,0)
  // sample); each later frame starts with a (0,0) pixel.
  task automatic test_cursor_blink;
    int   n, base;
    logic exp_pix;
    reset = 1'b1;
    @(posedge vga_clk); #1;
    reset = 1'b0;
    glyph_mode  = 1;
    cursor_addr = 13'd3;
    cen_dflt    = 1'b1;
    cell_mem[3] = 4'd9;
    for (int f = 0; f < 6; f++) begin
      n = 0;
      if (f > 0) begin set_px(n, 1'b1, 0, 0); n++; end
      base = n;
      for (int c = 0; c < 8; c++) begin set_px(n, 1'b1, 0, 24 + c); n++; end
      if (f == 3) for (int c = 4; c < 8; c++) seq_cen[base + c] = 1'b0;
      drive_seq(n);
      if (f > 0) begin
        checks++;
        if (obs_pix[4] !== 1'b0) begin errors++; $display("FAIL blink_cell0 frame %0d got %0b exp 0", f, obs_pix[4]); end
      end
      for (int c = 0; c < 8; c++) begin
        exp_pix = (f == 2 || f == 3) && !(f == 3 && c >= 4);
        checks++;
        if (obs_pix[base + c + 4] !== exp_pix) begin
          errors++;
          $display("FAIL blink_cell3 frame %0d px %0d got %0b exp %0b", f, c, obs_pix[base + c + 4], exp_pix);
        end
      end
    end
    cen_dflt  = 1'b0;
    cursor_en = 1'b0;
  endtask

  task automatic test_reset_midline;
    glyph_mode = 2;
    for (int j = 0; j < 10; j++) set_px(j, 1'b1, 10, 290 + j);
    set_px(10, 1'b1, 10, 300);
    seq_rst[10] = 1'b1;
    for (int j = 11; j < 14; j++) set_px(j, 1'b0, 10, 301);
    for (int j = 14; j < 22; j++) set_px(j, 1'b1, 10, 290 + j);
    drive_seq(22);
    checks++; if (obs_valid[9] !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %0b exp 1", obs_valid[9]); end
    checks++; if (obs_rd[10] !== 1'b0) begin errors++; $display("FAIL midrst_rd got %0b exp 0", obs_rd[10]); end
    checks++; if (obs_addr[10] !== 13'd0) begin errors++; $display("FAIL midrst_addr got %0d exp 0", obs_addr[10]); end
    checks++; if (obs_gaddr[10] !== 10'd0) begin errors++; $display("FAIL midrst_gaddr got %0d exp 0", obs_gaddr[10]); end
    checks++; if (obs_pix[10] !== 1'b0) begin errors++; $display("FAIL midrst_pix got %0b exp 0", obs_pix[10]); end
    checks++; if (obs_valid[10] !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b exp 0", obs_valid[10]); end
    for (int j = 11; j < 26; j++) begin
      checks++;
      if (obs_valid[j] !== (j >= 18)) begin errors++; $display("FAIL resume_valid[%0d] got %0b exp %0b", j, obs_valid[j], (j >= 18)); end
    end
    checks++; if (obs_pix[18] !== 1'b1) begin errors++; $display("FAIL resume_pix got %0b exp 1", obs_pix[18]); end
  endtask

  task automatic test_back_to_back;
    logic exp_pix;
    glyph_mode  = 3;
    cell_mem[0] = 4'd15;
    cell_mem[1] = 4'd0;
    for (int c = 0; c < 16; c++) set_px(c, 1'b1, 0, c);
    drive_seq(16);
    checks++; if (obs_rd[8] !== 1'b1) begin errors++; $display("FAIL b2b_rd_col8 got %0b exp 1", obs_rd[8]); end
    checks++; if (obs_addr[8] !== 13'd1) begin errors++; $display("FAIL b2b_addr_col8 got %0d exp 1", obs_addr[8]); end
    checks++; if (obs_gaddr[9] !== 10'd967) begin errors++; $display("FAIL b2b_gaddr_col7 got %0d exp 967", obs_gaddr[9]); end
    checks++; if (obs_gaddr[10] !== 10'd0) begin errors++; $display("FAIL b2b_gaddr_col8 got %0d exp 0", obs_gaddr[10]); end
    for (int j = 4; j < 20; j++) begin
      exp_pix = (j - 4) < 8;
      checks++;
      if (obs_pix[j] !== exp_pix) begin errors++; $display("FAIL b2b_pix col %0d got %0b exp %0b", j - 4, obs_pix[j], exp_pix); end
    end
  endtask

  initial begin
    reset = 1'b1; video_on = 1'b0; cursor_en = 1'b0; cen_dflt = 1'b0;
    pixel_row = '0; pixel_column = '0; cursor_addr = '0; glyph_mode = 0;
    for (int i = 0; i < 8192; i++) cell_mem[i] = 4'd0;
    @(posedge vga_clk); #1;
    test_reset;
    test_glyph_cell;
    test_addr;
    test_out_of_range;
    test_cursor_blink;
    test_reset_midline;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
